// File: rtl/sobel_edge_stream_if.sv
// sobel_edge_stream_if: pixel-in / edge-out stream bundle for the Sobel detector
interface sobel_edge_stream_if #(
    parameter int DW = 8
);
    logic          pix_vld;
    logic          pix_sof;
    logic [DW-1:0] pix_data;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;

    modport master (
        output pix_vld, pix_sof, pix_data,
        input  out_vld, out_data, out_sof, out_eol, out_eof
    );

    modport slave (
        input  pix_vld, pix_sof, pix_data,
        output out_vld, out_data, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel edge detector with line buffers and frame markers
module sobel_edge_stream #(
    parameter int IMG_W   = 200,
    parameter int IMG_H   = 200,
    parameter int DW      = 8,
    parameter int THR_DEF = 3
) (
    input  logic           sclk,
    input  logic           rst,
    sobel_edge_stream_if.slave bus,
    input  logic           mode,
    input  logic           thr_sel,
    input  logic [DW+3:0]  thr,
    output logic           sync_err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [DW+3:0] THR_D    = (DW+4)'(THR_DEF);
    localparam logic [DW+3:0] SAT      = (DW+4)'((1 << DW) - 1);

    logic [CW-1:0]        col, pc;
    logic [RW-1:0]        row, pr;
    logic                 origin, resync;
    logic [DW-1:0]        lb_a [IMG_W];
    logic [DW-1:0]        lb_b [IMG_W];
    logic [DW-1:0]        rd_a, rd_b;
    logic [DW-1:0]        p [3][3];
    logic                 f_mode, m1, m2;
    logic [DW+3:0]        f_thr, t1, t2;
    logic                 v1, v2;
    logic [2:0]           fl1, fl2;
    logic signed [DW+2:0] gx_c, gy_c, gx, gy;
    logic [DW+2:0]        ax, ay;
    logic [DW+3:0]        mag;
    logic [DW-1:0]        res;

    function automatic logic signed [DW+2:0] x1(input logic [DW-1:0] a);
        return $signed({3'b000, a});
    endfunction

    function automatic logic signed [DW+2:0] x2(input logic [DW-1:0] a);
        return $signed({2'b00, a, 1'b0});
    endfunction

    // position of the accepted pixel (sof forces origin), line-buffer reads and Sobel math
    always_comb begin
        pc     = bus.pix_sof ? '0 : col;
        pr     = bus.pix_sof ? '0 : row;
        origin = (col == '0) && (row == '0);
        resync = bus.pix_vld && bus.pix_sof && !origin;
        rd_a   = lb_a[pc];
        rd_b   = lb_b[pc];
        gx_c   = (x1(p[0][2]) + x2(p[1][2]) + x1(p[2][2]))
               - (x1(p[0][0]) + x2(p[1][0]) + x1(p[2][0]));
        gy_c   = (x1(p[0][0]) + x2(p[0][1]) + x1(p[0][2]))
               - (x1(p[2][0]) + x2(p[2][1]) + x1(p[2][2]));
        ax     = gx[DW+2] ? $unsigned(-gx) : $unsigned(gx);
        ay     = gy[DW+2] ? $unsigned(-gy) : $unsigned(gy);
        mag    = {1'b0, ax} + {1'b0, ay};
        res    = m2 ? (mag > SAT ? '1 : mag[DW-1:0]) : (mag >= t2 ? '1 : '0);
    end

    // raster counters advance once per accepted pixel, continuing from the forced position
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.pix_vld) begin
            col <= (pc == COL_LAST) ? '0 : pc + 1'b1;
            row <= (pc != COL_LAST) ? pr : (pr == ROW_LAST) ? '0 : pr + 1'b1;
        end
    end

    // line buffers and window shift; stale contents are masked by the row gating on v1
    always_ff @(posedge sclk) begin
        if (bus.pix_vld) begin
            lb_b[pc] <= rd_a;
            lb_a[pc] <= bus.pix_data;
            for (int i = 0; i < 3; i++) begin
                p[i][0] <= p[i][1];
                p[i][1] <= p[i][2];
            end
            p[0][2] <= rd_b;
            p[1][2] <= rd_a;
            p[2][2] <= bus.pix_data;
        end
    end

    // frame config capture, valid-tracked pipeline and registered outputs
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            sync_err     <= 1'b0;
            f_mode       <= 1'b0;
            f_thr        <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            fl1          <= '0;
            fl2          <= '0;
            m1           <= 1'b0;
            m2           <= 1'b0;
            t1           <= '0;
            t2           <= '0;
            gx           <= '0;
            gy           <= '0;
            bus.out_vld  <= 1'b0;
            bus.out_data <= '0;
            bus.out_sof  <= 1'b0;
            bus.out_eol  <= 1'b0;
            bus.out_eof  <= 1'b0;
        end else begin
            sync_err <= resync;
            if (bus.pix_vld && pc == '0 && pr == '0) begin
                f_mode <= mode;
                f_thr  <= thr_sel ? thr : THR_D;
            end
            v1  <= bus.pix_vld && pr >= RW'(2) && pc >= CW'(2);
            fl1 <= {pr == RW'(2) && pc == CW'(2), pc == COL_LAST, pr == ROW_LAST && pc == COL_LAST};
            m1  <= f_mode;
            t1  <= f_thr;
            v2  <= v1 && !resync;
            fl2 <= fl1;
            m2  <= m1;
            t2  <= t1;
            gx  <= gx_c;
            gy  <= gy_c;
            bus.out_vld  <= v2 && !resync;
            bus.out_data <= (v2 && !resync) ? res : '0;
            bus.out_sof  <= v2 && !resync && fl2[2];
            bus.out_eol  <= v2 && !resync && fl2[1];
            bus.out_eof  <= v2 && !resync && fl2[0];
        end
    end
endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream: scoreboard bench for the Sobel stream against a windowed-image model
module tb_sobel_edge_stream;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          thr_sel = 1'b0;
    logic [DW+3:0] thr = '0;
    logic          sync_err;

    sobel_edge_stream_if #(.DW(DW)) bus();

    sobel_edge_stream #(.IMG_W(W), .IMG_H(H), .DW(DW), .THR_DEF(3)) dut (
        .sclk(sclk), .rst(rst), .bus(bus), .mode(mode),
        .thr_sel(thr_sel), .thr(thr), .sync_err(sync_err)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    typedef struct {
        int d;
        bit s;
        bit l;
        bit e;
        int c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   img[H][W];
    int   exp_serr = -1;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Sobel on the stored image around centre (r,c), then threshold or saturate
    function automatic int model(input int r, input int c, input bit m, input int th);
        int wt[3] = '{1, 2, 1};
        int gx = 0;
        int gy = 0;
        int mag;
        for (int i = 0; i < 3; i++) begin
            gx += wt[i] * (img[r-1+i][c+1] - img[r-1+i][c-1]);
            gy += wt[i] * (img[r-1][c-1+i] - img[r+1][c-1+i]);
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return m ? (mag > 255 ? 255 : mag) : (mag >= th ? 255 : 0);
    endfunction

    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = kind == 0 ? 100 : kind == 1 ? (c < 2 ? 0 : 200) :
                            kind == 2 ? 10 * r : int'($urandom_range(0, 255));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sclk);
            bus.pix_vld = 1'b0;
            bus.pix_sof = 1'b0;
        end
    endtask

    task automatic send(input bit use_sof, input bit m, input bit ts, input int th,
                        input int gap_max, input int npix, input bit chk, input bit serr);
        int t = ts ? th : 3;
        for (int k = 0; k < npix; k++) begin
            int r = k / W;
            int c = k % W;
            @(negedge sclk);
            bus.pix_vld  = 1'b1;
            bus.pix_data = 8'(img[r][c]);
            bus.pix_sof  = use_sof && k == 0;
            if (k == 0) begin
                mode    = m;
                thr_sel = ts;
                thr     = 12'(th);
                if (serr) exp_serr = cyc + 1;
            end else begin
                mode    = 1'($urandom);
                thr_sel = 1'($urandom);
                thr     = 12'($urandom_range(0, 4095));
            end
            if (chk && r >= 2 && c >= 2)
                sb.push_back('{model(r-1, c-1, m, t), r == 2 && c == 2, c == W-1,
                               r == H-1 && c == W-1, cyc + 3});
            repeat ($urandom_range(0, gap_max)) begin
                @(negedge sclk);
                bus.pix_vld = 1'b0;
                bus.pix_sof = 1'b0;
            end
        end
    endtask

    // monitor: pop the scoreboard on every output strobe and watch sync_err timing
    always @(negedge sclk) begin
        if (!rst) begin
            if (sync_err || cyc == exp_serr) check("sync_err", int'(sync_err), int'(cyc == exp_serr));
            if (bus.out_vld) begin
                if (sb.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("out_data", int'(bus.out_data), mon_e.d);
                    check("out_sof", int'(bus.out_sof), int'(mon_e.s));
                    check("out_eol", int'(bus.out_eol), int'(mon_e.l));
                    check("out_eof", int'(bus.out_eof), int'(mon_e.e));
                    check("latency", cyc, mon_e.c);
                end
            end
        end
    end

    initial begin
        bus.pix_vld  = 1'b0;
        bus.pix_sof  = 1'b0;
        bus.pix_data = '0;
        repeat (3) @(negedge sclk);
        check("rst_out_vld", int'(bus.out_vld), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_sof", int'(bus.out_sof), 0);
        check("rst_out_eol", int'(bus.out_eol), 0);
        check("rst_out_eof", int'(bus.out_eof), 0);
        check("rst_sync_err", int'(sync_err), 0);
        rst = 1'b0;
        fill(0); send(1, 0, 0, 0, 0, W*H, 1, 0); idle(6);
        fill(1); send(1, 1, 0, 0, 0, W*H, 1, 0); idle(6);
        fill(2); send(1, 1, 0, 0, 0, W*H, 1, 0); idle(6);
        send(1, 0, 1, 80, 0, W*H, 1, 0); idle(6);
        send(1, 0, 1, 81, 0, W*H, 1, 0); idle(6);
        repeat (6) begin
            fill(3);
            send(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 1100)), 4, W*H, 1, 0);
            idle(6);
        end
        fill(3); send(0, 0, 0, 0, 0, 8, 0, 0);
        send(1, 1, 0, 0, 0, W*H, 1, 1); idle(6);
        fill(3); send(1, 1, 0, 0, 0, 15, 1, 0);
        @(posedge sclk);
        #2;
        check("pre_rst_out_vld", int'(bus.out_vld), 1);
        rst = 1'b1;
        bus.pix_vld = 1'b0;
        #1;
        check("mid_rst_out_vld", int'(bus.out_vld), 0);
        check("mid_rst_out_data", int'(bus.out_data), 0);
        sb.delete();
        @(negedge sclk);
        rst = 1'b0;
        fill(3); send(0, 1, 0, 0, 0, W*H, 1, 0); idle(6);
        fill(3); send(1, 1, 0, 0, 0, W*H, 1, 0);
        fill(3); send(1, 0, 1, int'($urandom_range(100, 700)), 0, W*H, 1, 0);
        fill(2); send(1, 1, 0, 0, 0, W*H, 1, 0);
        idle(1);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge sclk);
        check("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Parametrised streaming 3x3 Sobel edge detector for raster-order pixel streams (UART/camera front end to display/TX back end).
- Supersedes the fixed 200x200, 8-bit, FIFO-IP based line-buffer design.
- Uses inferred two-row line buffers, explicit border gating, a valid-tracked pipeline, and runtime selection of threshold or magnitude output.
- Adds frame markers and frame-sync error detection.

Parameters:
IMG_W, 200, pixels per line (>=3)
IMG_H, 200, lines per frame (>=3)
DW, 8, pixel data width
THR_DEF, 3, threshold used when thr_sel=0

Ports:
sclk  input  1  system clock
rst  input  1  asynchronous active-high reset
pix_vld  input  1  pixel strobe; one pixel accepted per high cycle
pix_sof  input  1  first pixel of frame, qualified by pix_vld
pix_data  input  DW  pixel value, unsigned
mode  input  1  0 = binary edge map, 1 = saturated gradient magnitude
thr_sel  input  1  0 = use THR_DEF, 1 = use thr
thr  input  DW+4  runtime threshold
out_vld  output  1  output pixel strobe
out_data  output  DW  edge or magnitude value
out_sof  output  1  first interior output of frame, with out_vld
out_eol  output  1  last output of an interior line, with out_vld
out_eof  output  1  last output of frame, with out_vld
sync_err  output  1  one-cycle pulse on unexpected pix_sof

Behaviour:
- Reset: every output 0; col/row counters 0; pipeline valids 0. Line-buffer RAM is not cleared; row gating makes stale contents harmless.
- Input counters advance only on pix_vld: col 0..IMG_W-1, then wraps to 0 and row increments; row IMG_H-1 with col IMG_W-1 wraps both to 0.
- pix_sof with pix_vld forces the accepted pixel to position (0,0); counters continue from (0,1).
- If pix_sof arrives while counters are not at (0,0), sync_err pulses 1 cycle and the frame restarts.
- Pipeline valid bits are flushed on that resync, so no partial-window output is produced.
- Line buffers: two IMG_W x DW arrays, lb_a = previous row and lb_b = row before that. On each pix_vld at column col:
  - read lb_a[col] and lb_b[col];
  - write lb_b[col] <= old lb_a[col];
  - write lb_a[col] <= pix_data.
- Window: 3x3 shift registers p[r][c], r0 = oldest row, c2 = newest column, shifted only on pix_vld.
- Window valid when the accepted pixel has row>=2 and col>=2. Window centre is (row-1, col-1).
- Borders (row 0, row IMG_H-1, col 0, col IMG_W-1) produce no output.
- Output count is (IMG_W-2)*(IMG_H-2) per frame.
- Arithmetic: signed, width DW+3, no overflow.
  - Gx = (p0c2 + 2*p1c2 + p2c2) - (p0c0 + 2*p1c0 + p2c0)
  - Gy = (p0c0 + 2*p0c1 + p0c2) - (p2c0 + 2*p2c1 + p2c2)
  - mag = |Gx| + |Gy|, unsigned, width DW+4.
- Mode 0: out_data = all ones if mag >= threshold, else 0.
- Mode 1: out_data = min(mag, 2^DW-1).
- mode, thr_sel and thr are sampled when pixel (0,0) is accepted and held for the whole frame. Changes mid-frame take effect next frame.
- Pipeline stages, advancing every sclk with a valid bit:
  - S1: window register load.
  - S2: Gx/Gy registered.
  - S3: abs, sum and threshold/saturate, registered to outputs.
- Latency: out_vld asserts exactly 3 sclk after the pix_vld cycle that completed the window. Gaps in pix_vld create matching gaps in out_vld; no stalls, no backpressure.
- out_sof for centre (1,1). out_eol for centre col IMG_W-2. out_eof for centre (IMG_H-2, IMG_W-2).
- Back-to-back frames with no gap are supported: the final window of frame N and the first pixels of frame N+1 coexist in the pipeline.
- Reset mid-frame: outputs drop to 0 within the reset cycle; operation resumes at the next pixel, treated as (0,0).

Test Plan:
- IMG_W=5, IMG_H=4, mode 0, thr_sel 0, constant 100 frame -> 6 out_vld, all out_data=0; out_sof on 1st output, out_eol on 3rd and 6th, out_eof on 6th.
- Same size, cols 0-1 = 0 and cols 2-4 = 200, mode 1 -> each output row 255,255,0 (mag 800 saturates).
- Row r = 10*r, mode 1 -> all outputs 80. Mode 0, thr_sel 1, thr=80 -> 255. thr=81 -> 0.
- Random pix_vld gaps (0-4 idle cycles) -> each out_vld exactly 3 cycles after the completing pix_vld; output count 6; data matches gap-free run.
- pix_sof at (row1, col3) -> sync_err 1-cycle pulse, no output from partial frame, next out_sof after 2 full new lines plus 3 pixels.
- rst pulse mid-frame, then a clean frame -> no spurious out_vld; full 6 correct outputs. Two back-to-back frames -> 12 outputs, 2 out_sof, 2 out_eof.
